pc_ras_unit: RTL and testbench

Parametrised program counter for the IF stage, successor to the single-width sequential/jump PC. Adds a configurable address width, step and reset vector, plus a highest-priority redirect (flush) path. Adds a circular return-address stack (RAS) so call/return flow is resolved in IF without waiting for the register file. Drives pc_curr to instruction memory and the IF/ID pipeline register.

---
 rtl/pc_ras_unit.sv | 125 ++++++++++++
 tb/tb_pc_ras_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: IF-stage program counter with flush redirect, jump/call and a circular return-address stack.
// Latency: a request sampled on a rising clk edge sets pc_curr after that same edge (no extra cycle).
// Backpressure: stall holds PC, RAS and flags; flush_valid overrides stall; no ready/credit handshake.
//
// Ports:
//    clk, rst          rising-edge clock; asynchronous active-high reset
//    stall             hold PC and RAS
//    flush_valid/pc    highest-priority redirect
//    jump_cs/target    taken jump; with call, also pushes pc_curr+STEP
//    ret               pop RAS into PC
//    pc_curr           registered fetch address
//    ras_count         valid RAS entries
//    ras_overflow      sticky: a push overwrote a valid entry
//    ret_miss          pulse: ret with empty RAS
//    call_ret_err      pulse: call and ret together
module pc_ras_unit #(
   parameter int          ADDR_W    = 32,
   parameter int          STEP      = 1,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int          RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         flush_valid,
   input  logic [ADDR_W-1:0]            flush_pc,
   input  logic                         jump_cs,
   input  logic [ADDR_W-1:0]            jump_target,
   input  logic                         call,
   input  logic                         ret,
   output logic [ADDR_W-1:0]            pc_curr,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow,
   output logic                         ret_miss,
   output logic                         call_ret_err
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] pc_q, pc_n;
   logic [ADDR_W-1:0] pc_seq;
   // ptr_q is the slot the next push writes; the top entry lives at ptr_q-1.
   logic [PW-1:0]     ptr_q, ptr_n;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic              ovf_q, ovf_n;
   logic              miss_q, miss_n;
   logic              cre_q, cre_n;
   logic              push;
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

   // Modulo 2^ADDR_W wrap falls out of the truncating add.
   assign pc_seq = pc_q + ADDR_W'(STEP);

   always_comb begin
      pc_n   = pc_q;
      ptr_n  = ptr_q;
      cnt_n  = cnt_q;
      ovf_n  = ovf_q;
      miss_n = 1'b0;
      cre_n  = 1'b0;
      push   = 1'b0;
      if (flush_valid) begin
         pc_n = flush_pc;
      end else if (stall) begin
         pc_n = pc_q;
      end else if (ret) begin
         cre_n = call;
         if (cnt_q != '0) begin
            pc_n  = ras_mem[ptr_q - PW'(1)];
            ptr_n = ptr_q - PW'(1);
            cnt_n = cnt_q - CW'(1);
         end else begin
            pc_n   = pc_seq;
            miss_n = 1'b1;
         end
      end else if (jump_cs) begin
         pc_n = jump_target;
         if (call) begin
            push  = 1'b1;
            ptr_n = ptr_q + PW'(1);
            // Full stack: the push lands on the oldest slot, count saturates.
            if (cnt_q == CW'(RAS_DEPTH)) begin
               ovf_n = 1'b1;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
      end else begin
         pc_n = pc_seq;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_VEC;
         ptr_q  <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         miss_q <= 1'b0;
         cre_q  <= 1'b0;
      end else begin
         pc_q   <= pc_n;
         ptr_q  <= ptr_n;
         cnt_q  <= cnt_n;
         ovf_q  <= ovf_n;
         miss_q <= miss_n;
         cre_q  <= cre_n;
      end
   end

   // Stack storage carries no reset; validity is tracked by cnt_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         ras_mem[ptr_q] <= pc_seq;
      end
   end

   assign pc_curr      = pc_q;
   assign ras_count    = cnt_q;
   assign ras_overflow = ovf_q;
   assign ret_miss     = miss_q;
   assign call_ret_err = cre_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: directed vectors with hand-computed expectations for pc_ras_unit.
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the next one.
// Backpressure: stall/flush exercised directly as stimulus.
module tb_pc_ras_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush_valid, jump_cs, call, ret;
   logic [31:0] flush_pc, jump_target;
   logic [31:0] pc_curr;
   logic [2:0]  ras_count;
   logic        ras_overflow, ret_miss, call_ret_err;

   logic        rst8;
   logic [7:0]  pc8;
   logic [2:0]  cnt8;
   logic        ovf8, miss8, cre8;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   pc_ras_unit #(.ADDR_W(32), .STEP(1), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush_valid(flush_valid), .flush_pc(flush_pc),
      .jump_cs(jump_cs), .jump_target(jump_target), .call(call), .ret(ret),
      .pc_curr(pc_curr), .ras_count(ras_count), .ras_overflow(ras_overflow),
      .ret_miss(ret_miss), .call_ret_err(call_ret_err)
   );

   pc_ras_unit #(.ADDR_W(8), .STEP(1), .RESET_VEC(8'hFF), .RAS_DEPTH(4)) dut8 (
      .clk(clk), .rst(rst8), .stall(1'b0), .flush_valid(1'b0), .flush_pc(8'h00),
      .jump_cs(1'b0), .jump_target(8'h00), .call(1'b0), .ret(1'b0),
      .pc_curr(pc8), .ras_count(cnt8), .ras_overflow(ovf8),
      .ret_miss(miss8), .call_ret_err(cre8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; flush_valid = 0; jump_cs = 0; call = 0; ret = 0;
   endtask

   task automatic do_call(input logic [31:0] tgt);
      jump_cs = 1; call = 1; jump_target = tgt;
      tick();
      idle();
   endtask

   task automatic do_flush(input logic [31:0] tgt);
      flush_valid = 1; flush_pc = tgt;
      tick();
      idle();
   endtask

   // Expected return addresses after five nested calls into a 4-deep stack.
   logic [31:0] ret_exp [4] = '{32'h81, 32'h61, 32'h41, 32'h21};

   initial begin
      idle();
      flush_pc = 0; jump_target = 0;
      rst = 1; rst8 = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Reset state
      chk("rst_pc",   pc_curr, 32'h100);
      chk("rst_cnt",  32'(ras_count), 0);
      chk("rst_ovf",  32'(ras_overflow), 0);
      chk("rst_miss", 32'(ret_miss), 0);
      chk("rst_cre",  32'(call_ret_err), 0);

      // Free-running sequential fetch
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("seq_pc", pc_curr, 32'h100 + 32'(i));
      end

      // Asynchronous reset mid-run, between clock edges
      #2 rst = 1;
      #1 chk("async_rst_pc", pc_curr, 32'h100);
      @(posedge clk); #1 rst = 0;

      // Call / sequential / return
      do_flush(32'h10);
      chk("flush_pc", pc_curr, 32'h10);
      do_call(32'h80);
      chk("call_pc",  pc_curr, 32'h80);
      chk("call_cnt", 32'(ras_count), 1);
      tick(); chk("body_pc1", pc_curr, 32'h81);
      tick(); chk("body_pc2", pc_curr, 32'h82);
      ret = 1; tick(); idle();
      chk("ret_pc",  pc_curr, 32'h11);
      chk("ret_cnt", 32'(ras_count), 0);

      // Five nested calls overflow a 4-deep stack
      do_flush(32'h0);
      for (int i = 1; i <= 5; i++) begin
         do_call(32'h20 * 32'(i));
         chk("nest_pc", pc_curr, 32'h20 * 32'(i));
         if (i == 4) chk("nest_ovf_before", 32'(ras_overflow), 0);
      end
      chk("nest_cnt", 32'(ras_count), 4);
      chk("nest_ovf", 32'(ras_overflow), 1);
      for (int i = 0; i < 4; i++) begin
         ret = 1; tick(); idle();
         chk("pop_pc",  pc_curr, ret_exp[i]);
         chk("pop_cnt", 32'(ras_count), 32'(3 - i));
      end
      ret = 1; tick(); idle();
      chk("miss_pc",   pc_curr, 32'h22);
      chk("miss_flag", 32'(ret_miss), 1);
      chk("miss_cnt",  32'(ras_count), 0);
      tick();
      chk("miss_pulse_end", 32'(ret_miss), 0);
      chk("miss_seq_pc",    pc_curr, 32'h23);
      chk("ovf_sticky",     32'(ras_overflow), 1);

      // Flush overrides stall and a pending ret
      do_call(32'h300);
      chk("push1_cnt", 32'(ras_count), 1);
      stall = 1; flush_valid = 1; flush_pc = 32'h200; ret = 1;
      tick(); idle();
      chk("flush_stall_pc",  pc_curr, 32'h200);
      chk("flush_stall_cnt", 32'(ras_count), 1);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc",  pc_curr, 32'h200);
         chk("stall_cnt", 32'(ras_count), 1);
      end
      idle();

      // call + ret + jump together: ret wins, error pulses once
      jump_cs = 1; call = 1; ret = 1; jump_target = 32'h400;
      tick(); idle();
      chk("cre_pc",   pc_curr, 32'h24);
      chk("cre_cnt",  32'(ras_count), 0);
      chk("cre_flag", 32'(call_ret_err), 1);
      tick();
      chk("cre_pulse_end", 32'(call_ret_err), 0);
      chk("cre_seq_pc",    pc_curr, 32'h25);

      // call without jump_cs is ignored
      call = 1; tick(); idle();
      chk("call_only_cnt", 32'(ras_count), 0);
      chk("call_only_pc",  pc_curr, 32'h26);

      // 8-bit PC wraps from 0xFF to 0x00 silently
      rst8 = 0;
      chk("w8_rst_pc", 32'(pc8), 32'hFF);
      tick();
      chk("w8_wrap_pc", 32'(pc8), 32'h00);
      chk("w8_flags",   32'({ovf8, miss8, cre8}), 0);
      chk("w8_cnt",     32'(cnt8), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
